// File: rtl/serial_seq_detector.sv
// Serial bit-pattern detector: flags each occurrence of PATTERN[LEN-1:0] in the valid bit stream
// and keeps a saturating match count. Define SEQ_DET_NONOVERLAP_EN to forbid overlapping matches.
module serial_seq_detector #(
  parameter logic [15:0] PATTERN = 16'b1011,
  parameter int          LEN     = 4,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN-1:0]   history
);

  localparam int               FILL_W   = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
  localparam logic [LEN-1:0]   PAT      = PATTERN[LEN-1:0];

  logic [LEN-1:0]    history_q, history_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              match_q, match_d;

  logic [LEN-1:0]    hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  generate
    if (LEN == 1) begin : g_len1
      assign hist_shift = din;
    end else begin : g_lenn
      assign hist_shift = {history_q[LEN-2:0], din};
    end
  endgenerate

  // A match needs LEN valid bits since reset/clear so a zero-filled history never fires.
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign hit      = (hist_shift == PAT) && (fill_inc == FILL_MAX);

  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    count_d   = count_q;
    match_d   = 1'b0;
    if (clear) begin
      history_d = '0;
      fill_d    = '0;
      count_d   = '0;
    end else if (din_valid) begin
      history_d = hist_shift;
      fill_d    = fill_inc;
      match_d   = hit;
      if (hit && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
`ifdef SEQ_DET_NONOVERLAP_EN
      if (hit) begin
        fill_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      match_q   <= match_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign history     = history_q;

endmodule
